// File: rtl/crosshair_overlay_pkg.sv
// Shared definitions for the crosshair overlay.
// Contents:
//   - Raster coordinate widths (HCOUNT_W, VCOUNT_W) and the signed
//     difference width used for the distance tests.
//   - RGB888 colour constants.
//   - is_frame_start: true on the first pixel of a frame.
//   - abs_diff: magnitude of a signed difference of two zero-extended
//     coordinates.
package crosshair_overlay_pkg;

    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;
    localparam int COLOR_W  = 24;
    localparam int DIFF_W   = 12;

    localparam logic [COLOR_W-1:0] MAGENTA = 24'hFF00FF;
    localparam logic [COLOR_W-1:0] GREEN   = 24'h00FF00;
    localparam logic [COLOR_W-1:0] BLUE    = 24'h0000FF;

    function automatic logic is_frame_start(input logic [HCOUNT_W-1:0] h,
                                            input logic [VCOUNT_W-1:0] v);
        return (h == '0) && (v == '0);
    endfunction

    // Both operands are zero-extended screen coordinates, so the true
    // difference lies in -2047..2047. That range fits 12-bit two's
    // complement, which means the distance never wraps around a screen edge.
    function automatic logic [DIFF_W-1:0] abs_diff(input logic [DIFF_W-1:0] a,
                                                   input logic [DIFF_W-1:0] b);
        logic [DIFF_W-1:0] d;
        d = a - b;
        return d[DIFF_W-1] ? (~d + 1'b1) : d;
    endfunction

endpackage

// File: rtl/crosshair_channel.sv
// One crosshair channel: coordinate capture, frame-synchronous update,
// timeout/lost tracking and the hit test for the current pixel.
// Ports:
//   clk, reset    pixel clock, synchronous active-high reset
//   frame_start   first pixel of the frame (hcount==0 && vcount==0)
//   hcount/vcount current raster position
//   en            draw enable for this channel
//   x, y, valid   coordinate update, taken when valid is high
//   blink_phase   global blink phase (1 = lost crosshairs visible)
//   hit           combinational: this channel draws the current pixel
//   lost          registered: no update for TIMEOUT_FRAMES frame starts
module crosshair_channel
    import crosshair_overlay_pkg::*;
#(
    parameter int THICK_HALF     = 0,
    parameter int ARM_LEN        = 0,
    parameter int TIMEOUT_FRAMES = 30
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_start,
    input  logic [HCOUNT_W-1:0] hcount,
    input  logic [VCOUNT_W-1:0] vcount,
    input  logic                en,
    input  logic [HCOUNT_W-1:0] x,
    input  logic [VCOUNT_W-1:0] y,
    input  logic                valid,
    input  logic                blink_phase,
    output logic                hit,
    output logic                lost
);

    localparam int TW = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [TW-1:0]     TMAX = TW'(TIMEOUT_FRAMES);
    localparam logic [DIFF_W-1:0] TH   = DIFF_W'(THICK_HALF);
    localparam logic [DIFF_W-1:0] AL   = DIFF_W'(ARM_LEN);
    localparam logic              FULL = (ARM_LEN == 0);

    logic [HCOUNT_W-1:0] pend_x, act_x, eff_x;
    logic [VCOUNT_W-1:0] pend_y, act_y, eff_y;
    logic [TW-1:0]       cnt, cnt_next;
    logic                seen;   // a valid arrived since the last frame start
    logic [DIFF_W-1:0]   dx, dy;
    logic                v_arm, h_arm;

    // Coordinates that govern the current pixel. On the frame-start cycle
    // the frame's new coordinates apply immediately, with a coincident
    // valid overriding the pending value.
    always_comb begin
        eff_x = act_x;
        eff_y = act_y;
        if (frame_start) begin
            eff_x = valid ? x : pend_x;
            eff_y = valid ? y : pend_y;
        end
    end

    always_comb begin
        cnt_next = cnt;
        if (valid)
            cnt_next = '0;
        else if (frame_start && !seen && (cnt != TMAX))
            cnt_next = cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_x <= '0;
            pend_y <= '0;
            act_x  <= '0;
            act_y  <= '0;
            cnt    <= TMAX;
            seen   <= 1'b0;
            lost   <= 1'b1;
        end else begin
            if (valid) begin
                pend_x <= x;
                pend_y <= y;
            end
            if (frame_start) begin
                act_x <= eff_x;
                act_y <= eff_y;
            end
            cnt  <= cnt_next;
            // A valid on the frame-start cycle belongs to that frame start.
            seen <= frame_start ? 1'b0 : (seen | valid);
            lost <= (cnt_next == TMAX);
        end
    end

    assign dx = abs_diff({1'b0, hcount}, {1'b0, eff_x});
    assign dy = abs_diff({2'b0, vcount}, {2'b0, eff_y});

    assign v_arm = (dx <= TH) && (FULL || (dy <= AL));
    assign h_arm = (dy <= TH) && (FULL || (dx <= AL));
    assign hit   = en && (!lost || blink_phase) && (v_arm || h_arm);

endmodule

// File: rtl/crosshair_overlay.sv
// Multi-channel crosshair overlay on a streaming raster.
// Ports:
//   clk, reset  pixel clock, synchronous active-high reset
//   hcount      current pixel column (11 bits)
//   vcount      current pixel row (10 bits)
//   ch_en       per-channel draw enable
//   ch_x, ch_y  flattened per-channel coordinates (11 / 10 bits each)
//   ch_valid    per-channel update strobe
//   ch_color    flattened per-channel RGB888 colour
//   pixel       background pixel
//   pixel_out   composited pixel, one cycle after its hcount/vcount/pixel
//   ch_lost     per-channel lost flag
// Handshake: ch_valid[i] is a single-cycle qualifier with no back-pressure;
// ch_x/ch_y for channel i are taken on every cycle its bit is high.
module crosshair_overlay
    import crosshair_overlay_pkg::*;
#(
    parameter int NUM_CH         = 3,
    parameter int THICK_HALF     = 0,
    parameter int ARM_LEN        = 0,
    parameter int TIMEOUT_FRAMES = 30,
    parameter int BLINK_FRAMES   = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [HCOUNT_W-1:0]          hcount,
    input  logic [VCOUNT_W-1:0]          vcount,
    input  logic [NUM_CH-1:0]            ch_en,
    input  logic [HCOUNT_W*NUM_CH-1:0]   ch_x,
    input  logic [VCOUNT_W*NUM_CH-1:0]   ch_y,
    input  logic [NUM_CH-1:0]            ch_valid,
    input  logic [COLOR_W*NUM_CH-1:0]    ch_color,
    input  logic [COLOR_W-1:0]           pixel,
    output logic [COLOR_W-1:0]           pixel_out,
    output logic [NUM_CH-1:0]            ch_lost
);

    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [BW-1:0] BLAST = BW'(BLINK_FRAMES - 1);

    logic              frame_start;
    logic [BW-1:0]     frame_cnt;
    logic              blink_phase;
    logic [NUM_CH-1:0] hit;
    logic [COLOR_W-1:0] mix;

    assign frame_start = is_frame_start(hcount, vcount);

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt == BLAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        crosshair_channel #(
            .THICK_HALF     (THICK_HALF),
            .ARM_LEN        (ARM_LEN),
            .TIMEOUT_FRAMES (TIMEOUT_FRAMES)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .frame_start (frame_start),
            .hcount      (hcount),
            .vcount      (vcount),
            .en          (ch_en[g]),
            .x           (ch_x[HCOUNT_W*g +: HCOUNT_W]),
            .y           (ch_y[VCOUNT_W*g +: VCOUNT_W]),
            .valid       (ch_valid[g]),
            .blink_phase (blink_phase),
            .hit         (hit[g]),
            .lost        (ch_lost[g])
        );
    end

    // Walk from the highest index down so the lowest-index hit is written last.
    always_comb begin
        mix = pixel;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (hit[i])
                mix = ch_color[COLOR_W*i +: COLOR_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            pixel_out <= '0;
        else
            pixel_out <= mix;
    end

endmodule

// File: tb/tb_crosshair_overlay.sv
module tb_crosshair_overlay;
    import crosshair_overlay_pkg::*;

    localparam int NC = 3;

    // Two instances share the stimulus: A uses the default geometry and
    // timing, B uses thick short arms with fast timeout and blink.
    localparam int TO_A = 30, BF_A = 16, TH_A = 0, AL_A = 0;
    localparam int TO_B = 5,  BF_B = 3,  TH_B = 1, AL_B = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [10:0]       hcount;
    logic [9:0]        vcount;
    logic [NC-1:0]     ch_en;
    logic [11*NC-1:0]  ch_x;
    logic [10*NC-1:0]  ch_y;
    logic [NC-1:0]     ch_valid;
    logic [24*NC-1:0]  ch_color;
    logic [23:0]       pixel;
    logic [23:0]       pixel_out_a, pixel_out_b;
    logic [NC-1:0]     ch_lost_a, ch_lost_b;

    always #5 clk = ~clk;

    crosshair_overlay #(
        .NUM_CH(NC), .THICK_HALF(TH_A), .ARM_LEN(AL_A),
        .TIMEOUT_FRAMES(TO_A), .BLINK_FRAMES(BF_A)
    ) dut_a (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .ch_en(ch_en), .ch_x(ch_x), .ch_y(ch_y), .ch_valid(ch_valid),
        .ch_color(ch_color), .pixel(pixel),
        .pixel_out(pixel_out_a), .ch_lost(ch_lost_a)
    );

    crosshair_overlay #(
        .NUM_CH(NC), .THICK_HALF(TH_B), .ARM_LEN(AL_B),
        .TIMEOUT_FRAMES(TO_B), .BLINK_FRAMES(BF_B)
    ) dut_b (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .ch_en(ch_en), .ch_x(ch_x), .ch_y(ch_y), .ch_valid(ch_valid),
        .ch_color(ch_color), .pixel(pixel),
        .pixel_out(pixel_out_b), .ch_lost(ch_lost_b)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [23:0]   pa;
        logic [23:0]   pb;
        logic [NC-1:0] la;
        logic [NC-1:0] lb;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    int p_to[2], p_bf[2], p_th[2], p_al[2];
    int m_px[2][NC], m_py[2][NC];   // latest captured coordinate
    int m_fx[2][NC], m_fy[2][NC];   // coordinate the current frame draws
    int m_miss[2][NC];              // frame starts without an update
    bit m_fresh[2][NC];             // updated since the last frame start
    int m_frames[2];
    bit m_vis[2];
    logic [23:0] col[NC];

    // Stimulus for the current cycle.
    bit          st_rst;
    int          st_h, st_v;
    logic [NC-1:0] st_en, st_valid;
    int          st_x[NC], st_y[NC];
    logic [23:0] st_pix;
    int          tx[NC], ty[NC];

    function automatic bit on_cross(int h, int v, int x, int y, int th, int al);
        int dx, dy;
        dx = (h > x) ? h - x : x - h;
        dy = (v > y) ? v - y : y - v;
        return (dx <= th && (al == 0 || dy <= al)) ||
               (dy <= th && (al == 0 || dx <= al));
    endfunction

    task automatic model_step(input int d, output logic [23:0] pix,
                              output logic [NC-1:0] lost);
        bit fs;
        fs = (st_h == 0) && (st_v == 0);
        if (st_rst) begin
            for (int c = 0; c < NC; c++) begin
                m_px[d][c] = 0; m_py[d][c] = 0;
                m_fx[d][c] = 0; m_fy[d][c] = 0;
                m_miss[d][c] = p_to[d];
                m_fresh[d][c] = 0;
            end
            m_frames[d] = 0;
            m_vis[d] = 0;
            pix = '0;
            lost = '1;
            return;
        end
        // A new frame takes the latest coordinate, including one arriving now.
        if (fs)
            for (int c = 0; c < NC; c++) begin
                m_fx[d][c] = st_valid[c] ? st_x[c] : m_px[d][c];
                m_fy[d][c] = st_valid[c] ? st_y[c] : m_py[d][c];
            end
        pix = st_pix;
        for (int c = 0; c < NC; c++) begin
            bit shown;
            shown = st_en[c] && (m_miss[d][c] < p_to[d] || m_vis[d]);
            if (shown && on_cross(st_h, st_v, m_fx[d][c], m_fy[d][c], p_th[d], p_al[d])) begin
                pix = col[c];
                break;
            end
        end
        for (int c = 0; c < NC; c++) begin
            if (st_valid[c]) begin
                m_px[d][c] = st_x[c];
                m_py[d][c] = st_y[c];
                m_miss[d][c] = 0;
            end else if (fs && !m_fresh[d][c] && m_miss[d][c] < p_to[d]) begin
                m_miss[d][c]++;
            end
            if (fs) m_fresh[d][c] = 0;
            else if (st_valid[c]) m_fresh[d][c] = 1;
            lost[c] = (m_miss[d][c] == p_to[d]);
        end
        if (fs) begin
            m_frames[d]++;
            if (m_frames[d] == p_bf[d]) begin
                m_frames[d] = 0;
                m_vis[d] = !m_vis[d];
            end
        end
    endtask

    // Drive the current stimulus onto the DUT inputs and queue the response.
    task automatic apply();
        exp_t e;
        reset  = st_rst;
        hcount = 11'(st_h);
        vcount = 10'(st_v);
        ch_en  = st_en;
        ch_valid = st_valid;
        pixel  = st_pix;
        for (int c = 0; c < NC; c++) begin
            ch_x[11*c +: 11] = 11'(st_x[c]);
            ch_y[10*c +: 10] = 10'(st_y[c]);
        end
        model_step(0, e.pa, e.la);
        model_step(1, e.pb, e.lb);
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
        end
    endtask

    // Monitor: one registered response per clock, popped in order.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pixel_a", {8'h0, pixel_out_a}, {8'h0, e.pa});
                check("pixel_b", {8'h0, pixel_out_b}, {8'h0, e.pb});
                check("lost_a",  32'(ch_lost_a), 32'(e.la));
                check("lost_b",  32'(ch_lost_b), 32'(e.lb));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycle(input int h, input int v, input logic [NC-1:0] vld,
                         input int x0, input int y0);
        @(negedge clk);
        st_rst = 0;
        st_h = h; st_v = v;
        st_valid = vld;
        for (int c = 0; c < NC; c++)
            if (vld[c]) begin
                st_x[c] = x0 + 100 * c;
                st_y[c] = y0 + 30 * c;
                tx[c] = st_x[c]; ty[c] = st_y[c];
            end
        st_pix = 24'($urandom);
        apply();
    endtask

    function automatic int pick_x();
        int r;
        r = $urandom_range(5);
        return (r == 0) ? 0 : (r == 1) ? 2047 : $urandom_range(2047);
    endfunction

    function automatic int pick_y();
        int r;
        r = $urandom_range(5);
        return (r == 0) ? 0 : (r == 1) ? 1023 : $urandom_range(1023);
    endfunction

    task automatic rand_cycle(input int valid_pct, input int fs_pct);
        int r, c, edge_h[5], edge_v[4];
        edge_h = '{0, 1, 2, 2046, 2047};
        edge_v = '{0, 5, 6, 1023};
        @(negedge clk);
        st_rst = 0;
        r = $urandom_range(99);
        if (r < fs_pct) begin
            st_h = 0; st_v = 0;
        end else begin
            r = $urandom_range(3);
            c = $urandom_range(NC - 1);
            if (r == 0) begin
                st_h = $urandom_range(2047);
                st_v = $urandom_range(1023);
            end else if (r == 3) begin
                st_h = edge_h[$urandom_range(4)];
                st_v = edge_v[$urandom_range(3)];
            end else begin
                st_h = (tx[c] + $urandom_range(14) - 7) & 2047;
                st_v = (ty[c] + $urandom_range(14) - 7) & 1023;
            end
        end
        for (int k = 0; k < NC; k++) begin
            st_valid[k] = ($urandom_range(99) < valid_pct);
            if (st_valid[k]) begin
                st_x[k] = pick_x();
                st_y[k] = pick_y();
                tx[k] = st_x[k]; ty[k] = st_y[k];
            end
        end
        if ($urandom_range(99) < 3)
            st_en = NC'($urandom);
        st_pix = 24'($urandom);
        apply();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int guard;
        p_to = '{TO_A, TO_B}; p_bf = '{BF_A, BF_B};
        p_th = '{TH_A, TH_B}; p_al = '{AL_A, AL_B};
        col = '{MAGENTA, GREEN, BLUE};
        for (int c = 0; c < NC; c++) ch_color[24*c +: 24] = col[c];
        st_en = '1; st_valid = '0; st_pix = '0;
        for (int c = 0; c < NC; c++) begin
            st_x[c] = 0; st_y[c] = 0; tx[c] = 0; ty[c] = 0;
        end
        st_h = 0; st_v = 0;

        // Reset for two cycles.
        st_rst = 1;
        repeat (2) begin
            @(negedge clk);
            apply();
        end

        // Mid-frame update: channel 0 to (100,50), channel 1 to (200,80).
        cycle(500, 300, 3'b011, 100, 50);
        cycle(100, 300, 3'b000, 0, 0);
        cycle(200, 50, 3'b000, 0, 0);
        cycle(0, 0, 3'b000, 0, 0);
        cycle(100, 700, 3'b000, 0, 0);
        cycle(900, 50, 3'b000, 0, 0);
        cycle(100, 80, 3'b000, 0, 0);
        cycle(200, 80, 3'b000, 0, 0);
        cycle(101, 51, 3'b000, 0, 0);

        // Update on the exact frame-start cycle.
        cycle(0, 0, 3'b001, 300, 200);
        cycle(300, 10, 3'b000, 0, 0);
        cycle(600, 200, 3'b000, 0, 0);

        // Mixed random traffic.
        repeat (3000) rand_cycle(2, 3);
        // Starve updates so channels time out and blink.
        repeat (4000) rand_cycle(0, 10);
        // Recover with a single update per channel, then steady traffic.
        cycle(700, 400, 3'b111, 40, 60);
        repeat (20) cycle(40, $urandom_range(1023), 3'b000, 0, 0);
        repeat (2000) rand_cycle(1, 4);

        // Reset in the middle of a line, then resume.
        cycle(399, 120, 3'b000, 0, 0);
        @(negedge clk);
        st_rst = 1; st_h = 400; st_v = 120; st_valid = '0; st_pix = 24'($urandom);
        apply();
        cycle(401, 120, 3'b000, 0, 0);
        cycle(402, 120, 3'b000, 0, 0);
        repeat (1500) rand_cycle(2, 5);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            #2;
            guard++;
        end
        n_checks++;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
